bus_ctrl: RTL and testbench
===========================

# bus_ctrl

Parametrised, registered system-bus controller between the MIPS core's load/store port and N memory-mapped peripherals (RAM, GPIO, PWM, …). Decodes a request address into a one-hot slave select, runs a request/ready handshake with variable-latency slaves, and returns registered read data. Unmapped addresses are flagged with a bus error, and an optional watchdog terminates stalled accesses.

## Interface
- `N_SLAVES`, default 6: number of slave ports. Range 1..2^`IDX_W`.
- `REGION_LSB`, default 12: lowest address bit of the region index.
- `IDX_W`, default 3: region index width.
- `TIMEOUT_CYCLES`, default 16: ACCESS cycles allowed before a timeout. Range ≥1; used only with `BUS_TIMEOUT_EN`.
- `clk` in 1: single clock; all logic samples on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `bReq` in 1: master request; sampled only in IDLE.
- `bWe` in 1: 1 = write, 0 = read.
- `bAddr` in 32: byte address.
- `bWData` in 32: write data.
- `bRData` out 32: registered read data, valid while `bReady`=1.
- `bReady` out 1: one-cycle completion pulse.
- `bErr` out 1: error flag, valid with `bReady`.
- `sSel` out `N_SLAVES`: one-hot slave select; high for the whole ACCESS phase.
- `sWe` out 1: write strobe to the selected slave.
- `sAddr` out 32: latched full address.
- `sWData` out 32: latched write data.
- `sRData` in 32*`N_SLAVES`: flattened slave read data; slave i occupies bits [32i+31:32i].
- `sReady` in `N_SLAVES`: per-slave completion; only the selected slave's bit is observed.

## Operation
- **Decode:**
  - idx = `bAddr`[`REGION_LSB`+`IDX_W`-1 : `REGION_LSB`].
  - The address is mapped iff idx < `N_SLAVES` and `bAddr`[31 : `REGION_LSB`+`IDX_W`] == 0.
- **FSM states:** IDLE, ACCESS, DONE.
- **IDLE:**
  - When `bReq`=1, latch `bAddr`, `bWe`, `bWData`.
  - If mapped: latch sel = one-hot(idx) and go to ACCESS.
  - If unmapped: set err=1 and `bRData`=0, then go to DONE; no slave is selected.
- **ACCESS:**
  - `sSel`=sel, and `sWe`=latched we.
  - When `sReady`[idx]=1: capture the selected `sRData` slice into `bRData` (captured for writes too), clear `sSel`/`sWe`, go to DONE with err=0.
- **DONE:**
  - `bReady`=1 for exactly one cycle; `bErr` = err.
  - Return to IDLE.
  - `bRData` holds its value until the next capture.
- **Request handling:**
  - `bReq` is ignored outside IDLE; the master must not issue a new request before `bReady`.
  - `bReq` high in the same cycle as `bReady` is not accepted. It is accepted on the following cycle only if still high.
- **Stray ready:** `sReady` bits of non-selected slaves, or any `sReady` bit seen in IDLE/DONE, are ignored.
- **Reset:**
  - Reset values: state IDLE; `bReady`=0, `bErr`=0, `bRData`=0, `sSel`=0, `sWe`=0, `sAddr`=0, `sWData`=0; timeout counter 0.
  - Reset mid-ACCESS aborts the transfer; no `bReady` is issued for it.

## Timing
- Request accepted at edge T0 → `sSel`/`sWe` valid after T0.
- Zero-wait slave (`sReady`=1 in the first ACCESS cycle) → `bReady` high in the cycle after edge T1, i.e. 2 cycles from `bReq` to `bReady`.
- Each cycle of slave wait adds 1 cycle.
- Unmapped access → `bReady`/`bErr` in the cycle after T0 (1-cycle latency).
- Back-to-back throughput: one access per 3 cycles minimum (IDLE, ACCESS, DONE).
- No combinational path from any input to any output.

## Configuration
- **`BUS_TIMEOUT_EN` defined:**
  - A counter of width clog2(`TIMEOUT_CYCLES`+1) clears on entry to ACCESS and increments each ACCESS cycle without ready.
  - When the count reaches `TIMEOUT_CYCLES` with no ready, FSM goes to DONE with err=1, `bRData`=0, and `sSel`/`sWe` cleared.
  - If `sReady` arrives in the same cycle the limit is reached, the ready wins (normal completion, err=0).
- **`BUS_TIMEOUT_EN` undefined:** no counter exists; ACCESS waits indefinitely and `bErr` is asserted only for unmapped addresses.

## Test plan
- **Read, zero-wait:** read `bAddr`=0x0000_1004 with slave1 `sReady`=1 and `sRData` slice = 0xCAFE_0001 → `sSel`=6'b000010 for 1 cycle, `bReady` 2 cycles after `bReq`, `bRData`=0xCAFE_0001, `bErr`=0.
- **Write, 3 wait states:** write `bAddr`=0x0000_2010, `bWData`=0x0000_00FF to slave2 (ready on its 4th ACCESS cycle) → `sWe`=1 and `sWData`=0xFF for 4 cycles, `bReady` 5 cycles after request, `bErr`=0.
- **Unmapped addresses:**
  - `bAddr`=0x0000_7000 (idx 7 ≥ 6) → `bReady`+`bErr`=1 one cycle later, `sSel` never set.
  - `bAddr`=0x0001_0000 (nonzero high bits) → same response.
- **Timeout (`BUS_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16):** slave0 never ready → `bErr`=1 with `bRData`=0 after 16 ACCESS cycles. Repeat with ready asserted on exactly the 16th cycle → `bErr`=0 and data returned.
- **Reset mid-access:** `rst` pulsed in the 2nd ACCESS cycle → next cycle all outputs at reset values and no `bReady`. A fresh request then completes normally.
- **Stray ready / blocked request:** `sReady`=6'b111111 while slave3 is selected → only slave3's data is captured. `bReq` held high during ACCESS is not re-accepted until IDLE.

Source files
------------

// File: rtl/bus_ctrl.sv
// ============================================================================
// bus_ctrl
// ----------------------------------------------------------------------------
// Registered system-bus controller between the core's load/store port and
// N_SLAVES memory-mapped peripherals.
//
// A request is decoded into a one-hot slave select using address bits
// [REGION_LSB+IDX_W-1 : REGION_LSB]. The address is mapped only when that
// index is below N_SLAVES and every address bit above the index field is
// zero. A mapped access holds the select for the whole ACCESS phase until
// the selected slave raises its ready bit. The controller then returns the
// registered read data with a one-cycle bReady pulse. An unmapped access
// completes one cycle after acceptance with bErr=1 and bRData=0.
//
// Optional feature (compile-time macro BUS_TIMEOUT_EN):
//   When this macro is defined, a watchdog ends an ACCESS phase after
//   TIMEOUT_CYCLES cycles without ready. The access then completes with
//   bErr=1 and bRData=0. If ready arrives in the same cycle the limit is
//   reached, ready wins. When the macro is undefined, no counter exists and
//   ACCESS waits indefinitely.
//
// Handshake: the master raises bReq while the controller is IDLE. bReq is
// sampled only in IDLE. The master must not raise a new request before it
// sees bReady. bReady is high for exactly one cycle per accepted request,
// and bErr/bRData are valid while bReady is high. A slave completes by
// raising its own sReady bit while its sSel bit is high. Any other sReady
// activity is ignored.
//
// Ports:
//   clk          : clock; all state changes on the rising edge
//   rst          : synchronous, active-high reset
//   bReq         : master request (sampled only in IDLE)
//   bWe          : 1 = write, 0 = read
//   bAddr        : byte address
//   bWData       : write data
//   bRData       : registered read data, valid with bReady
//   bReady       : one-cycle completion pulse
//   bErr         : error flag, valid with bReady
//   sSel         : one-hot slave select, high for the whole ACCESS phase
//   sWe          : write strobe to the selected slave
//   sAddr        : latched full address
//   sWData       : latched write data
//   sRData       : flattened slave read data, slave i at [32i+31:32i]
//   sReady       : per-slave completion
//   dbg_state_o  : current FSM state (0 IDLE, 1 ACCESS, 2 DONE)
// ============================================================================
module bus_ctrl #(
    parameter int N_SLAVES       = 6,
    parameter int REGION_LSB     = 12,
    parameter int IDX_W          = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bReq,
    input  logic                  bWe,
    input  logic [31:0]           bAddr,
    input  logic [31:0]           bWData,
    output logic [31:0]           bRData,
    output logic                  bReady,
    output logic                  bErr,
    output logic [N_SLAVES-1:0]   sSel,
    output logic                  sWe,
    output logic [31:0]           sAddr,
    output logic [31:0]           sWData,
    input  logic [32*N_SLAVES-1:0] sRData,
    input  logic [N_SLAVES-1:0]   sReady,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // N_SLAVES can be as large as 2^IDX_W. One extra bit is needed to hold it.
    localparam logic [IDX_W:0] N_SLV = (IDX_W + 1)'(N_SLAVES);
    localparam int             HI_LSB = REGION_LSB + IDX_W;

    state_t                state_q;
    logic [31:0]           b_rdata_q;
    logic                  b_ready_q;
    logic                  b_err_q;
    logic [N_SLAVES-1:0]   s_sel_q;
    logic                  s_we_q;
    logic [31:0]           s_addr_q;
    logic [31:0]           s_wdata_q;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]      cnt_q;
`endif

    // ------------------------------------------------------------------
    // Request decode and selected-slave return path.
    // These feed only registers, so no input reaches an output
    // combinationally.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]      req_idx;
    logic                  req_hi_zero;
    logic                  req_mapped;
    logic [N_SLAVES-1:0]   req_onehot;
    logic [31:0]           sel_rdata;
    logic                  sel_ready;

    always_comb begin
        req_idx     = bAddr[HI_LSB-1 -: IDX_W];
        // Shifting out the index and lower bits leaves only the bits that
        // must be zero for a mapped address.
        req_hi_zero = ((bAddr >> HI_LSB) == 32'd0);
        req_mapped  = ({1'b0, req_idx} < N_SLV) && req_hi_zero;

        req_onehot = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            req_onehot[i] = (req_idx == IDX_W'(i));
        end

        // The select is one-hot, so an AND-OR mux is enough. Ready bits of
        // slaves that are not selected are masked off here.
        sel_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (s_sel_q[i]) begin
                sel_rdata = sel_rdata | sRData[32*i +: 32];
            end
        end
        sel_ready = |(sReady & s_sel_q);
    end

    // ------------------------------------------------------------------
    // Controller FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            b_rdata_q <= '0;
            b_ready_q <= 1'b0;
            b_err_q   <= 1'b0;
            s_sel_q   <= '0;
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
`ifdef BUS_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    b_ready_q <= 1'b0;
                    if (bReq) begin
                        s_addr_q  <= bAddr;
                        s_wdata_q <= bWData;
                        if (req_mapped) begin
                            s_sel_q <= req_onehot;
                            s_we_q  <= bWe;
                            state_q <= ST_ACCESS;
`ifdef BUS_TIMEOUT_EN
                            cnt_q   <= '0;
`endif
                        end else begin
                            // Unmapped: no slave sees the access. Complete
                            // immediately with an error.
                            b_err_q   <= 1'b1;
                            b_rdata_q <= '0;
                            b_ready_q <= 1'b1;
                            state_q   <= ST_DONE;
                        end
                    end
                end

                ST_ACCESS: begin
                    if (sel_ready) begin
                        // Data is captured for writes as well.
                        b_rdata_q <= sel_rdata;
                        b_err_q   <= 1'b0;
                        b_ready_q <= 1'b1;
                        s_sel_q   <= '0;
                        s_we_q    <= 1'b0;
                        state_q   <= ST_DONE;
                    end
`ifdef BUS_TIMEOUT_EN
                    // The count before this cycle is (cycles waited - 1).
                    // Hitting the limit here means this is the last allowed
                    // ACCESS cycle, and ready has already lost the race.
                    else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        cnt_q     <= cnt_q + CNT_W'(1);
                        b_rdata_q <= '0;
                        b_err_q   <= 1'b1;
                        b_ready_q <= 1'b1;
                        s_sel_q   <= '0;
                        s_we_q    <= 1'b0;
                        state_q   <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end

                ST_DONE: begin
                    // bReady lasts exactly one cycle. bErr is cleared with it
                    // so that it is only ever seen together with bReady.
                    // bRData keeps its value.
                    b_ready_q <= 1'b0;
                    b_err_q   <= 1'b0;
                    state_q   <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bRData      = b_rdata_q;
    assign bReady      = b_ready_q;
    assign bErr        = b_err_q;
    assign sSel        = s_sel_q;
    assign sWe         = s_we_q;
    assign sAddr       = s_addr_q;
    assign sWData      = s_wdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bus_ctrl.sv
// ============================================================================
// tb_bus_ctrl
// ----------------------------------------------------------------------------
// Directed testbench for bus_ctrl with the default parameters:
// 6 slaves, REGION_LSB=12, IDX_W=3 and TIMEOUT_CYCLES=16.
// Inputs are driven 1 time unit after the rising edge. Outputs are observed
// at the same point, so they show the state left by the edge just passed.
// ============================================================================
module tb_bus_ctrl;

    localparam int NS = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              bReq;
    logic              bWe;
    logic [31:0]       bAddr;
    logic [31:0]       bWData;
    logic [31:0]       bRData;
    logic              bReady;
    logic              bErr;
    logic [NS-1:0]     sSel;
    logic              sWe;
    logic [31:0]       sAddr;
    logic [31:0]       sWData;
    logic [32*NS-1:0]  sRData;
    logic [NS-1:0]     sReady;
    logic [1:0]        dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected read data, pushed when a request is issued and popped at
    // bReady.
    logic [31:0] exp_q[$];
    logic [31:0] exp_d;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    bus_ctrl #(
        .N_SLAVES       (NS),
        .REGION_LSB     (12),
        .IDX_W          (3),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bReq        (bReq),
        .bWe         (bWe),
        .bAddr       (bAddr),
        .bWData      (bWData),
        .bRData      (bRData),
        .bReady      (bReady),
        .bErr        (bErr),
        .sSel        (sSel),
        .sWe         (sWe),
        .sAddr       (sAddr),
        .sWData      (sWData),
        .sRData      (sRData),
        .sReady      (sReady),
        .dbg_state_o (dbg_state)
    );

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bReq   = 1'b1;
        bWe    = we;
        bAddr  = addr;
        bWData = wdata;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst    = 1'b1;
        bReq   = 1'b0;
        bWe    = 1'b0;
        bAddr  = '0;
        bWData = '0;
        sReady = '0;
        // Slave data, slave5 down to slave0.
        sRData = {32'h5555_0005, 32'h4444_0004, 32'h3333_0003,
                  32'h2222_0002, 32'hCAFE_0001, 32'h1111_0000};
        tick;
        tick;
        n_cmp++;
        if ({bReady, bErr, sSel, sWe, dbg_state} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected %b", {bReady, bErr, sSel, sWe, dbg_state}, 11'b0);
        end
        n_cmp++;
        if ({bRData, sAddr, sWData} !== 96'b0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", {bRData, sAddr, sWData});
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_read_zero_wait;
        drive_req(1'b0, 32'h0000_1004, 32'h0);
        sReady = 6'b000010;
        tick;
        n_cmp++;
        if ({bReady, bErr, sSel, sWe} !== {1'b0, 1'b0, 6'b000010, 1'b0}) begin
            n_fail++;
            $display("FAIL rd_access: got %b expected %b", {bReady, bErr, sSel, sWe}, {1'b0, 1'b0, 6'b000010, 1'b0});
        end
        n_cmp++;
        if (sAddr !== 32'h0000_1004) begin
            n_fail++;
            $display("FAIL rd_saddr: got %h expected %h", sAddr, 32'h0000_1004);
        end
        bReq = 1'b0;
        exp_q.push_back(32'hCAFE_0001);
        tick;
        exp_d = exp_q.pop_front();
        n_cmp++;
        if ({bReady, bErr, sSel} !== {1'b1, 1'b0, 6'b0}) begin
            n_fail++;
            $display("FAIL rd_done: got %b expected %b", {bReady, bErr, sSel}, {1'b1, 1'b0, 6'b0});
        end
        n_cmp++;
        if (bRData !== exp_d) begin
            n_fail++;
            $display("FAIL rd_data: got %h expected %h", bRData, exp_d);
        end
        sReady = '0;
        tick;
        n_cmp++;
        if ({bReady, sSel, bRData} !== {1'b0, 6'b0, 32'hCAFE_0001}) begin
            n_fail++;
            $display("FAIL rd_after: got %h expected %h", {bReady, sSel, bRData}, {1'b0, 6'b0, 32'hCAFE_0001});
        end
    endtask

    task automatic test_write_wait;
        sReady = '0;
        drive_req(1'b1, 32'h0000_2010, 32'h0000_00FF);
        tick;
        bReq = 1'b0;
        exp_q.push_back(32'h2222_0002);
        for (int k = 1; k <= 4; k++) begin
            n_cmp++;
            if ({bReady, sSel, sWe, sWData} !== {1'b0, 6'b000100, 1'b1, 32'h0000_00FF}) begin
                n_fail++;
                $display("FAIL wr_access_%0d: got %h expected %h", k, {bReady, sSel, sWe, sWData}, {1'b0, 6'b000100, 1'b1, 32'h0000_00FF});
            end
            if (k == 4) sReady = 6'b000100;
            tick;
        end
        exp_d = exp_q.pop_front();
        n_cmp++;
        if ({bReady, bErr, sSel, sWe} !== {1'b1, 1'b0, 6'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL wr_done: got %b expected %b", {bReady, bErr, sSel, sWe}, {1'b1, 1'b0, 6'b0, 1'b0});
        end
        n_cmp++;
        if (bRData !== exp_d) begin
            n_fail++;
            $display("FAIL wr_data: got %h expected %h", bRData, exp_d);
        end
        sReady = '0;
        tick;
        n_cmp++;
        if (bReady !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_pulse: got %b expected 0", bReady);
        end
    endtask

    task automatic test_unmapped;
        logic [31:0] addrs [2];
        addrs[0] = 32'h0000_7000;
        addrs[1] = 32'h0001_0000;
        for (int n = 0; n < 2; n++) begin
            // All ready bits high in IDLE are stray and must not matter.
            sReady = 6'b111111;
            drive_req(n[0], addrs[n], 32'h1234_5678);
            tick;
            bReq = 1'b0;
            n_cmp++;
            if ({bReady, bErr, sSel, sWe} !== {1'b1, 1'b1, 6'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL unmapped_%0d_done: got %b expected %b", n, {bReady, bErr, sSel, sWe}, {1'b1, 1'b1, 6'b0, 1'b0});
            end
            n_cmp++;
            if (bRData !== 32'h0) begin
                n_fail++;
                $display("FAIL unmapped_%0d_data: got %h expected 0", n, bRData);
            end
            tick;
            n_cmp++;
            if ({bReady, bErr, sSel, sWe} !== 9'b0) begin
                n_fail++;
                $display("FAIL unmapped_%0d_after: got %b expected 0", n, {bReady, bErr, sSel, sWe});
            end
        end
        sReady = '0;
    endtask

    task automatic test_stray_ready_blocked;
        // Every slave except slave3 is ready. This must not end the access.
        sReady = 6'b110111;
        drive_req(1'b0, 32'h0000_3008, 32'h0);
        tick;
        n_cmp++;
        if (sSel !== 6'b001000) begin
            n_fail++;
            $display("FAIL stray_sel: got %b expected %b", sSel, 6'b001000);
        end
        tick;
        n_cmp++;
        if ({bReady, sSel} !== {1'b0, 6'b001000}) begin
            n_fail++;
            $display("FAIL stray_hold: got %b expected %b", {bReady, sSel}, {1'b0, 6'b001000});
        end
        sReady = 6'b111111;
        exp_q.push_back(32'h3333_0003);
        tick;
        exp_d = exp_q.pop_front();
        n_cmp++;
        if ({bReady, bErr, sSel, bRData} !== {1'b1, 1'b0, 6'b0, exp_d}) begin
            n_fail++;
            $display("FAIL stray_done: got %h expected %h", {bReady, bErr, sSel, bRData}, {1'b1, 1'b0, 6'b0, exp_d});
        end
        // bReq is still high during DONE. It must not be taken there.
        tick;
        n_cmp++;
        if ({bReady, sSel, dbg_state} !== {1'b0, 6'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL blocked_req: got %b expected %b", {bReady, sSel, dbg_state}, {1'b0, 6'b0, 2'd0});
        end
        // Back in IDLE with bReq still high, so it is accepted now.
        tick;
        n_cmp++;
        if (sSel !== 6'b001000) begin
            n_fail++;
            $display("FAIL reaccept_sel: got %b expected %b", sSel, 6'b001000);
        end
        bReq = 1'b0;
        tick;
        n_cmp++;
        if ({bReady, bRData} !== {1'b1, 32'h3333_0003}) begin
            n_fail++;
            $display("FAIL reaccept_done: got %h expected %h", {bReady, bRData}, {1'b1, 32'h3333_0003});
        end
        sReady = '0;
        tick;
    endtask

    task automatic test_reset_mid_access;
        sReady = '0;
        drive_req(1'b1, 32'h0000_0040, 32'hA5A5_5A5A);
        tick;
        bReq = 1'b0;
        n_cmp++;
        if ({sSel, sWe} !== {6'b000001, 1'b1}) begin
            n_fail++;
            $display("FAIL rstmid_access: got %b expected %b", {sSel, sWe}, {6'b000001, 1'b1});
        end
        tick;
        rst = 1'b1;
        tick;
        n_cmp++;
        if ({bReady, bErr, sSel, sWe, dbg_state} !== 11'b0) begin
            n_fail++;
            $display("FAIL rstmid_ctrl: got %b expected 0", {bReady, bErr, sSel, sWe, dbg_state});
        end
        n_cmp++;
        if ({bRData, sAddr, sWData} !== 96'b0) begin
            n_fail++;
            $display("FAIL rstmid_data: got %h expected 0", {bRData, sAddr, sWData});
        end
        rst = 1'b0;
        sReady = 6'b000001;
        tick;
        n_cmp++;
        if ({bReady, sSel} !== 7'b0) begin
            n_fail++;
            $display("FAIL rstmid_noready: got %b expected 0", {bReady, sSel});
        end
        drive_req(1'b0, 32'h0000_0000, 32'h0);
        exp_q.push_back(32'h1111_0000);
        tick;
        bReq = 1'b0;
        n_cmp++;
        if (sSel !== 6'b000001) begin
            n_fail++;
            $display("FAIL rstmid_fresh_sel: got %b expected %b", sSel, 6'b000001);
        end
        tick;
        exp_d = exp_q.pop_front();
        n_cmp++;
        if ({bReady, bErr, bRData} !== {1'b1, 1'b0, exp_d}) begin
            n_fail++;
            $display("FAIL rstmid_fresh_done: got %h expected %h", {bReady, bErr, bRData}, {1'b1, 1'b0, exp_d});
        end
        sReady = '0;
        tick;
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic test_timeout;
        for (int rep = 0; rep < 2; rep++) begin
            sReady = '0;
            drive_req(1'b0, 32'h0000_0100, 32'h0);
            tick;
            bReq = 1'b0;
            for (int k = 1; k <= 16; k++) begin
                n_cmp++;
                if ({bReady, sSel} !== {1'b0, 6'b000001}) begin
                    n_fail++;
                    $display("FAIL to_%0d_wait_%0d: got %b expected %b", rep, k, {bReady, sSel}, {1'b0, 6'b000001});
                end
                // On the second pass, ready arrives in the same cycle the
                // limit is reached, so the access completes normally.
                if (rep == 1 && k == 16) sReady = 6'b000001;
                tick;
            end
            n_cmp++;
            if ({bReady, bErr, sSel, sWe} !== {1'b1, (rep == 0), 6'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL to_%0d_done: got %b expected %b", rep, {bReady, bErr, sSel, sWe}, {1'b1, (rep == 0), 6'b0, 1'b0});
            end
            n_cmp++;
            if (bRData !== ((rep == 0) ? 32'h0 : 32'h1111_0000)) begin
                n_fail++;
                $display("FAIL to_%0d_data: got %h expected %h", rep, bRData, ((rep == 0) ? 32'h0 : 32'h1111_0000));
            end
            sReady = '0;
            tick;
        end
    endtask
`else
    task automatic test_long_wait;
        // Without the watchdog, a slave that takes 20 cycles must still be
        // waited for.
        sReady = '0;
        drive_req(1'b0, 32'h0000_0100, 32'h0);
        tick;
        bReq = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            n_cmp++;
            if ({bReady, bErr, sSel} !== {1'b0, 1'b0, 6'b000001}) begin
                n_fail++;
                $display("FAIL wait_%0d: got %b expected %b", k, {bReady, bErr, sSel}, {1'b0, 1'b0, 6'b000001});
            end
            if (k == 21) sReady = 6'b000001;
            tick;
        end
        n_cmp++;
        if ({bReady, bErr, sSel, bRData} !== {1'b1, 1'b0, 6'b0, 32'h1111_0000}) begin
            n_fail++;
            $display("FAIL wait_done: got %h expected %h", {bReady, bErr, sSel, bRData}, {1'b1, 1'b0, 6'b0, 32'h1111_0000});
        end
        sReady = '0;
        tick;
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset;
        test_read_zero_wait;
        test_write_wait;
        test_unmapped;
        test_stray_ready_blocked;
        test_reset_mid_access;
`ifdef BUS_TIMEOUT_EN
        test_timeout;
`else
        test_long_wait;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
